control_fsm: RTL
================

// Module: control_fsm
// PURPOSE
//   Multi-cycle control unit for the 16-bit RISC core; the producer side of the ALU's alu_sel/zero_flag interface.
//   Sequences FETCH/DECODE/EXEC/MEM/WB per instruction and drives the ALU, register-file, PC, IR and memory controls.
//   Consumes the ALU zero_flag for conditional branches.
//   Sits beside the datapath (IR, PC, regfile, ALU); talks to unified memory through a req/ready handshake.
// PARAMETERS
//   OPW       4  opcode width (instr[15:12])
//   ALU_SELW  3  ALU select width
// PORTS
//   clk        in   1         rising-edge clock
//   rst_n      in   1         asynchronous active-low reset
//   instr_op   in   OPW       opcode field of IR; valid from the cycle after ir_load
//   zero_flag  in   1         ALU result==0, combinational from the ALU
//   mem_ready  in   1         memory completes the current request this cycle
//   mem_req    out  1         memory request; held until mem_ready
//   mem_we     out  1         1=write (SW); valid only with mem_req
//   addr_sel   out  1         memory address: 0=PC, 1=ALU result
//   ir_load    out  1         latch memory read data into IR
//   pc_load    out  1         update PC this cycle
//   pc_src     out  2         0=PC+1, 1=PC+imm6 (branch), 2=jump target, 3=reserved
//   alu_sel    out  ALU_SELW  0 add, 1 sub, 2 not, 3 shl, 4 shr, 5 and, 6 or, 7 slt
//   alu_src_b  out  1         ALU B operand: 0=rs2, 1=sign-extended imm6
//   reg_we     out  1         regfile write enable
//   wb_sel     out  1         writeback source: 0=ALU result, 1=memory data
//   halted     out  1         core stopped
// BEHAVIOUR
//   Opcode map:
//     0-7  R-type; alu_sel = op[2:0]
//     8 LW, 9 SW, A BEQ, B BNE, C JMP, D ADDI, E NOP, F HALT
//   Reset:
//     State = FETCH; all outputs 0 (alu_sel=0, pc_src=0, halted=0).
//     Asserting rst_n mid-wait drops mem_req immediately; the cycle is abandoned.
//   FETCH:
//     mem_req=1, addr_sel=0.
//     While mem_ready=0: stay in FETCH, hold outputs.
//     On mem_ready: ir_load=1, pc_load=1, pc_src=0 -> DECODE.
//   DECODE:
//     One cycle; register instr_op into op_q -> EXEC.
//     alu_sel etc. come from op_q only, so IR changes are ignored afterwards.
//   EXEC:
//     Drives alu_sel and alu_src_b from op_q.
//     - R-type -> WB.
//     - ADDI: alu_sel=0, alu_src_b=1 -> WB.
//     - LW/SW: alu_sel=0, alu_src_b=1 -> MEM.
//     - BEQ/BNE: alu_sel=1, alu_src_b=0.
//       taken = zero_flag (BEQ) or !zero_flag (BNE), sampled this cycle.
//       If taken: pc_load=1, pc_src=1. Then -> FETCH.
//     - JMP: pc_load=1, pc_src=2 -> FETCH.
//     - NOP -> FETCH.
//     - HALT -> HALTED.
//   MEM:
//     Holds alu_sel/alu_src_b from EXEC so the address stays stable.
//     mem_req=1, addr_sel=1, mem_we=(op_q==SW); wait for mem_ready.
//     On ready: LW -> WB, SW -> FETCH.
//   WB:
//     reg_we=1 for exactly one cycle; wb_sel=(op_q==LW) -> FETCH.
//   HALTED:
//     halted=1, all other controls 0. Absorbing; exit only via rst_n.
//   Output timing:
//     mem_ready-qualified and zero_flag-qualified pulses are Mealy; all others are Moore on state/op_q.
//     ir_load, pc_load and reg_we are single-cycle pulses.
//     mem_ready in states other than FETCH/MEM is ignored.
//   Latency (zero-wait memory):
//     R-type/ADDI 4 cycles; LW 5; SW 4; BEQ/BNE/JMP/NOP 3; +1 cycle per mem_ready=0 cycle.
//   Invariants:
//     Never reg_we and mem_we together.
//     Never pc_load twice per instruction, except a taken branch (FETCH increment, then EXEC redirect).
// STRUCTURE
//   Shared package risc_pkg: opcode constants, ALU_* select codes (shared with the ALU), PC_SRC_* codes, state enum.
//   Sub-module control_decode: combinational op_q -> {alu_sel, alu_src_b, is_rtype, is_mem, is_br, is_jmp}.
//   control_fsm holds the state register, op_q and the output logic.
// TESTING
//   1. Reset, then op=0x6 (OR), ready always 1.
//      -> FETCH, DECODE, EXEC alu_sel=6, WB reg_we=1 once; next mem_req at cycle 4.
//   2. LW, ready low 2 cycles in FETCH and 3 in MEM.
//      -> mem_req held throughout; addr_sel=1 and alu_src_b=1 in MEM; WB wb_sel=1; total 10 cycles.
//   3. BEQ with zero_flag=1, then BNE with zero_flag=1.
//      -> first: pc_load=1 pc_src=1 in EXEC; second: no pc_load in EXEC.
//   4. SW -> mem_we=1 only while mem_req in MEM; reg_we never 1; returns to FETCH.
//   5. HALT, then toggle mem_ready and instr_op for 20 cycles -> halted=1, all controls 0.
//      rst_n low -> FETCH.
//   6. rst_n low during MEM wait of LW -> mem_req=0 asynchronously; after release, FETCH with no reg_we.

Source files
------------

// File: rtl/risc_pkg.sv
// Shared definitions for the 16-bit RISC core: opcodes, ALU selects, PC source codes, control states.
package risc_pkg;
   localparam int OPW      = 4;
   localparam int ALU_SELW = 3;

   localparam logic [3:0] OP_LW   = 4'h8;
   localparam logic [3:0] OP_SW   = 4'h9;
   localparam logic [3:0] OP_BEQ  = 4'hA;
   localparam logic [3:0] OP_BNE  = 4'hB;
   localparam logic [3:0] OP_JMP  = 4'hC;
   localparam logic [3:0] OP_ADDI = 4'hD;
   localparam logic [3:0] OP_NOP  = 4'hE;
   localparam logic [3:0] OP_HALT = 4'hF;

   localparam logic [2:0] ALU_ADD = 3'd0;
   localparam logic [2:0] ALU_SUB = 3'd1;
   localparam logic [2:0] ALU_NOT = 3'd2;
   localparam logic [2:0] ALU_SHL = 3'd3;
   localparam logic [2:0] ALU_SHR = 3'd4;
   localparam logic [2:0] ALU_AND = 3'd5;
   localparam logic [2:0] ALU_OR  = 3'd6;
   localparam logic [2:0] ALU_SLT = 3'd7;

   localparam logic [1:0] PC_SRC_INC = 2'd0;
   localparam logic [1:0] PC_SRC_BR  = 2'd1;
   localparam logic [1:0] PC_SRC_JMP = 2'd2;
   localparam logic [1:0] PC_SRC_RSV = 2'd3;

   typedef enum logic [2:0] {
      S_FETCH,
      S_DECODE,
      S_EXEC,
      S_MEM,
      S_WB,
      S_HALTED
   } state_t;
endpackage

// File: rtl/control_decode.sv
// Combinational opcode decode: ALU operation/operand selection and instruction class flags.
module control_decode
   import risc_pkg::*;
#(
   parameter int OPW      = 4,
   parameter int ALU_SELW = 3
) (
   input  logic [OPW-1:0]      i_op,
   output logic [ALU_SELW-1:0] o_alu_sel,
   output logic                o_alu_src_b,
   output logic                o_is_rtype,
   output logic                o_is_mem,
   output logic                o_is_br,
   output logic                o_is_jmp
);
   always_comb begin
      o_alu_sel   = ALU_SELW'(ALU_ADD);
      o_alu_src_b = 1'b0;
      o_is_rtype  = 1'b0;
      o_is_mem    = 1'b0;
      o_is_br     = 1'b0;
      o_is_jmp    = 1'b0;
      if (i_op < OPW'(8)) begin
         o_is_rtype = 1'b1;
         o_alu_sel  = i_op[ALU_SELW-1:0];
      end else begin
         case (i_op)
            OPW'(OP_LW), OPW'(OP_SW): begin
               o_is_mem    = 1'b1;
               o_alu_src_b = 1'b1;
            end
            OPW'(OP_ADDI): o_alu_src_b = 1'b1;
            OPW'(OP_BEQ), OPW'(OP_BNE): begin
               o_is_br   = 1'b1;
               o_alu_sel = ALU_SELW'(ALU_SUB);
            end
            OPW'(OP_JMP): o_is_jmp = 1'b1;
            default: ;
         endcase
      end
   end
endmodule

// File: rtl/control_fsm.sv
// Multi-cycle control unit: sequences fetch/decode/execute/memory/writeback and drives datapath controls.
//   state    | meaning
//   S_FETCH  | read instruction at PC; wait for mem_ready, then load IR and PC+1
//   S_DECODE | capture opcode into r_op_q
//   S_EXEC   | drive ALU; resolve branch/jump; pick next phase by class
//   S_MEM    | load/store data access at ALU address; wait for mem_ready
//   S_WB     | single-cycle register write (ALU or memory data)
//   S_HALTED | core stopped; only rst_n leaves
module control_fsm
   import risc_pkg::*;
#(
   parameter int OPW      = 4,
   parameter int ALU_SELW = 3
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [OPW-1:0]      instr_op,
   input  logic                zero_flag,
   input  logic                mem_ready,
   output logic                mem_req,
   output logic                mem_we,
   output logic                addr_sel,
   output logic                ir_load,
   output logic                pc_load,
   output logic [1:0]          pc_src,
   output logic [ALU_SELW-1:0] alu_sel,
   output logic                alu_src_b,
   output logic                reg_we,
   output logic                wb_sel,
   output logic                halted
);
   state_t               r_state, w_next;
   logic [OPW-1:0]       r_op_q;
   logic [ALU_SELW-1:0]  w_alu_sel;
   logic                 w_alu_src_b, w_is_rtype, w_is_mem, w_is_br, w_is_jmp;
   logic                 w_is_lw, w_is_sw, w_is_beq, w_is_addi, w_is_halt, w_br_taken;

   control_decode #(.OPW(OPW), .ALU_SELW(ALU_SELW)) u_decode (
      .i_op        (r_op_q),
      .o_alu_sel   (w_alu_sel),
      .o_alu_src_b (w_alu_src_b),
      .o_is_rtype  (w_is_rtype),
      .o_is_mem    (w_is_mem),
      .o_is_br     (w_is_br),
      .o_is_jmp    (w_is_jmp)
   );

   assign w_is_lw    = (r_op_q == OPW'(OP_LW));
   assign w_is_sw    = (r_op_q == OPW'(OP_SW));
   assign w_is_beq   = (r_op_q == OPW'(OP_BEQ));
   assign w_is_addi  = (r_op_q == OPW'(OP_ADDI));
   assign w_is_halt  = (r_op_q == OPW'(OP_HALT));
   assign w_br_taken = w_is_beq ? zero_flag : !zero_flag;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_FETCH;
         r_op_q  <= '0;
      end else begin
         r_state <= w_next;
         if (r_state == S_DECODE) r_op_q <= instr_op;
      end
   end

   // Outputs are gated by rst_n so an in-flight memory request drops the moment reset asserts.
   always_comb begin
      w_next    = r_state;
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      addr_sel  = 1'b0;
      ir_load   = 1'b0;
      pc_load   = 1'b0;
      pc_src    = PC_SRC_INC;
      alu_sel   = ALU_SELW'(ALU_ADD);
      alu_src_b = 1'b0;
      reg_we    = 1'b0;
      wb_sel    = 1'b0;
      halted    = 1'b0;
      if (rst_n) begin
         case (r_state)
            S_FETCH: begin
               mem_req = 1'b1;
               if (mem_ready) begin
                  ir_load = 1'b1;
                  pc_load = 1'b1;
                  w_next  = S_DECODE;
               end
            end
            S_DECODE: w_next = S_EXEC;
            S_EXEC: begin
               alu_sel   = w_alu_sel;
               alu_src_b = w_alu_src_b;
               if (w_is_rtype || w_is_addi) begin
                  w_next = S_WB;
               end else if (w_is_mem) begin
                  w_next = S_MEM;
               end else if (w_is_br) begin
                  pc_load = w_br_taken;
                  pc_src  = w_br_taken ? PC_SRC_BR : PC_SRC_INC;
                  w_next  = S_FETCH;
               end else if (w_is_jmp) begin
                  pc_load = 1'b1;
                  pc_src  = PC_SRC_JMP;
                  w_next  = S_FETCH;
               end else if (w_is_halt) begin
                  w_next = S_HALTED;
               end else begin
                  w_next = S_FETCH;
               end
            end
            S_MEM: begin
               alu_sel   = w_alu_sel;
               alu_src_b = w_alu_src_b;
               mem_req   = 1'b1;
               addr_sel  = 1'b1;
               mem_we    = w_is_sw;
               if (mem_ready) w_next = w_is_sw ? S_FETCH : S_WB;
            end
            // ALU selection is kept through WB so the written ALU result stays valid.
            S_WB: begin
               alu_sel   = w_alu_sel;
               alu_src_b = w_alu_src_b;
               reg_we    = 1'b1;
               wb_sel    = w_is_lw;
               w_next    = S_FETCH;
            end
            S_HALTED: halted = 1'b1;
            default: w_next = S_FETCH;
         endcase
      end
   end
endmodule
